// File: rtl/core_pkg.sv
// Shared pipeline-control definitions: controller states, register-zero index
// and the NOP encoding loaded into IF_ID on a flush.
package core_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. Purely combinational so the forwarding unit can share it.
module hazard_detect
  import core_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = use_rs1 && (rs1 == rd);
  assign rs2_hit  = use_rs2 && (rs2 == rd);
  // x0 is never written, so a load targeting it cannot create a hazard
  assign load_use = is_load && (rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush priority mux plus a memory-wait
// FSM with watchdog. Define HAZARD_PERF_CNT_EN to add the performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  input  logic       br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_br_flushes,
  output logic [31:0] perf_mem_stalls,
`endif
  output logic       err_sticky
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg;
  logic             err_reg;
  logic             load_use;
  logic             mem_busy;

  hazard_detect u_detect (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .rd       (ex_rd),
    .is_load  (ex_load),
    .load_use (load_use)
  );

  // In ABORT the outstanding access is dropped, so the pipeline must advance
  assign mem_busy = mem_req && !mem_ready && (state_reg != ABORT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready || !mem_req) begin
          state_next = RUN;
          cnt_next   = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          state_next = ABORT;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ABORT: begin
        state_next = RUN;
        cnt_next   = '0;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else if (br_taken) begin
        // wrong-path ID instruction is squashed, so its load-use is moot
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= (state_next == ABORT);
      if (state_next == ABORT) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_reg;
  assign err_sticky  = err_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_reg, br_cnt_reg, mem_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_reg  <= '0;
      br_cnt_reg  <= '0;
      mem_cnt_reg <= '0;
    end else begin
      if (mem_busy) begin
        mem_cnt_reg <= mem_cnt_reg + 32'd1;
      end else if (br_taken) begin
        br_cnt_reg <= br_cnt_reg + 32'd1;
      end else if (load_use) begin
        lu_cnt_reg <= lu_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_lu_stalls  = lu_cnt_reg;
  assign perf_br_flushes = br_cnt_reg;
  assign perf_mem_stalls = mem_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: constant vector table, hand-written
// multi-cycle sequences, then random stimulus against a cycle-count model.
module tb_hazard_ctrl;

  localparam int T = 4;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic       rst;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [5:0] exp;
  } tvec_t;

  // comb output patterns, order {pc, if_id_st, if_id_fl, id_ex_st, id_ex_fl, ex_mem_st}
  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_MEM  = 6'b110101;
  localparam logic [5:0] P_BR   = 6'b001010;
  localparam logic [5:0] P_LU   = 6'b110010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, br_taken, mem_req, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic       mem_timeout, err_sticky;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_br_flushes, perf_mem_stalls;
  int unsigned m_lu, m_br, m_mem;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_load      (ex_load),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_timeout  (mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_stalls  (perf_lu_stalls),
    .perf_br_flushes (perf_br_flushes),
    .perf_mem_stalls (perf_mem_stalls),
`endif
    .err_sticky   (err_sticky)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: number of consecutive stalled memory cycles, abort flag, error flag
  int m_busy_run = 0;
  bit m_abort    = 1'b0;
  bit m_err      = 1'b0;

  tvec_t tq[$];

  function automatic vec_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                              input int rd, input bit ld, input bit br,
                              input bit req, input bit rdy, input bit rst);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
    v.rd = 5'(rd); v.ld = ld; v.br = br; v.req = req; v.rdy = rdy; v.rst = rst;
    return v;
  endfunction

  function automatic bit m_busy(input vec_t v);
    return v.req && !v.rdy && !m_abort;
  endfunction

  function automatic bit m_lu_hit(input vec_t v);
    return v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
  endfunction

  function automatic logic [7:0] model_out(input vec_t v);
    logic [5:0] c;
    if (v.rst)              c = P_NONE;
    else if (m_busy(v))     c = P_MEM;
    else if (v.br)          c = P_BR;
    else if (m_lu_hit(v))   c = P_LU;
    else                    c = P_NONE;
    return {c, m_abort, m_err};
  endfunction

  task automatic model_update(input vec_t v);
    bit busy;
    busy = m_busy(v);
    if (v.rst) begin
      m_busy_run = 0; m_abort = 1'b0; m_err = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      m_lu = 0; m_br = 0; m_mem = 0;
`endif
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (busy) m_mem++;
      else if (v.br) m_br++;
      else if (m_lu_hit(v)) m_lu++;
`endif
      if (m_abort) begin
        m_abort = 1'b0; m_busy_run = 0;
      end else if (busy) begin
        m_busy_run++;
        if (m_busy_run == T) begin
          m_abort = 1'b1; m_err = 1'b1; m_busy_run = 0;
        end
      end else begin
        m_busy_run = 0;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_load = v.ld; br_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy; reset = v.rst;
  endtask

  task automatic apply(input vec_t v, input logic [7:0] exp, input bit use_model, input string name);
    logic [7:0] e, got;
    @(negedge clk);
    drive(v);
    #1;
    e   = use_model ? model_out(v) : exp;
    got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_timeout, err_sticky};
    n_cmp++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, e);
    end else begin
      $display("ok   %s: out=%b", name, got);
    end
    @(posedge clk);
    model_update(v);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic check_perf(input string name);
    @(negedge clk);
    n_cmp++;
    if (perf_lu_stalls !== m_lu || perf_br_flushes !== m_br || perf_mem_stalls !== m_mem) begin
      n_fail++;
      $display("FAIL %s: got lu=%0d br=%0d mem=%0d expected lu=%0d br=%0d mem=%0d", name,
               perf_lu_stalls, perf_br_flushes, perf_mem_stalls, m_lu, m_br, m_mem);
    end else begin
      $display("ok   %s: lu=%0d br=%0d mem=%0d", name, m_lu, m_br, m_mem);
    end
  endtask
`endif

  initial begin
    vec_t idle, rstv, lu5, memw, v;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lu5  = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    memw = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    tq.push_back('{v: lu5,                                 exp: P_LU});
    tq.push_back('{v: mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0),    exp: P_NONE});
    tq.push_back('{v: mk(3, 7, 0, 1, 7, 1, 0, 0, 0, 0),    exp: P_LU});
    tq.push_back('{v: mk(5, 5, 0, 0, 5, 1, 0, 0, 0, 0),    exp: P_NONE});
    tq.push_back('{v: mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0),    exp: P_NONE});
    tq.push_back('{v: mk(4, 0, 1, 0, 5, 1, 0, 0, 0, 0),    exp: P_NONE});
    tq.push_back('{v: mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0),    exp: P_BR});
    tq.push_back('{v: mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),    exp: P_BR});
    tq.push_back('{v: mk(5, 0, 1, 0, 5, 1, 0, 1, 1, 0),    exp: P_LU});
    tq.push_back('{v: mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),    exp: P_NONE});

    // first reset cycle: registers are still unknown, so only clock it in
    @(negedge clk);
    drive(rstv);
    @(posedge clk);
    model_update(rstv);
    apply(rstv, {P_NONE, 2'b00}, 1'b0, "reset_state");

    foreach (tq[i]) apply(tq[i].v, {tq[i].exp, 2'b00}, 1'b0, $sformatf("table%0d", i));

    apply(lu5, {P_LU, 2'b00}, 1'b0, "lu_cycle1");
    v = lu5; v.ld = 1'b0;
    apply(v, {P_NONE, 2'b00}, 1'b0, "lu_cycle2_released");

    for (int i = 0; i < 3; i++) apply(memw, {P_MEM, 2'b00}, 1'b0, $sformatf("memwait%0d", i));
    v = memw; v.rdy = 1'b1;
    apply(v, {P_NONE, 2'b00}, 1'b0, "memwait_release");
    apply(idle, {P_NONE, 2'b00}, 1'b0, "memwait_idle");

    v = memw; v.br = 1'b1;
    for (int i = 0; i < 3; i++) apply(v, {P_MEM, 2'b00}, 1'b0, $sformatf("wait_masks_br%0d", i));
    v.rdy = 1'b1;
    apply(v, {P_BR, 2'b00}, 1'b0, "wait_release_br");
    apply(idle, {P_NONE, 2'b00}, 1'b0, "wait_br_idle");

    for (int i = 0; i < T; i++) apply(memw, {P_MEM, 2'b00}, 1'b0, $sformatf("timeout_wait%0d", i));
    apply(memw, {P_NONE, 2'b11}, 1'b0, "timeout_pulse");
    apply(memw, {P_MEM, 2'b01}, 1'b0, "after_abort_rewait");
    apply(idle, {P_NONE, 2'b01}, 1'b0, "err_sticky_hold1");
    apply(idle, {P_NONE, 2'b01}, 1'b0, "err_sticky_hold2");

    apply(memw, {P_MEM, 2'b01}, 1'b0, "rst_midwait_c1");
    v = memw; v.rst = 1'b1;
    apply(v, {P_NONE, 2'b01}, 1'b0, "rst_midwait_c2");
    apply(idle, {P_NONE, 2'b00}, 1'b0, "rst_midwait_after");
`ifdef HAZARD_PERF_CNT_EN
    check_perf("perf_after_reset");
`endif
    apply(memw, {P_MEM, 2'b00}, 1'b0, "rst_fresh_wait");
    apply(idle, {P_NONE, 2'b00}, 1'b0, "rst_fresh_idle");

    for (int i = 0; i < 300; i++) begin
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.ld  = 1'($urandom_range(0, 1));
      v.br  = ($urandom_range(0, 3) == 0);
      v.req = ($urandom_range(0, 3) != 0);
      v.rdy = ($urandom_range(0, 4) == 0);
      v.rst = ($urandom_range(0, 63) == 0);
      apply(v, 8'h00, 1'b1, $sformatf("rand%0d", i));
    end
`ifdef HAZARD_PERF_CNT_EN
    check_perf("perf_after_random");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. It decides, each cycle, whether each pipeline register (PC, IF_ID, ID_EX, EX_MEM) loads, holds or is flushed to a bubble.
- Inputs: load-use hazards, taken branches/jumps from EX, and a data-memory ready handshake.
- A small FSM tracks multi-cycle memory waits and a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles before timeout abort (≥2).
- CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  Rd_out of ID_EX
- ex_load  in  1  ID_EX holds a load (WB_sel_out selects memory)
- br_taken  in  1  EX resolved taken branch/jump this cycle
- mem_req  in  1  MEM stage issues data-memory access
- mem_ready  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF_ID
- if_id_flush  out  1  load IF_ID with NOP
- id_ex_stall  out  1  hold ID_EX
- id_ex_flush  out  1  load ID_EX with bubble (all controls 0)
- ex_mem_stall  out  1  hold EX_MEM
- mem_timeout  out  1  one-cycle pulse on watchdog abort
- err_sticky  out  1  set by timeout, cleared only by reset

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - state=RUN, wait_cnt=0, err_sticky=0, mem_timeout=0.
  - All combinational outputs evaluate to 0 while reset is high.
- States:
  - RUN: normal.
  - WAIT: memory access outstanding.
  - ABORT: single cycle after timeout.
- Signal definitions:
  - mem_busy = mem_req & ~mem_ready & (state≠ABORT).
  - load_use = ex_load & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Output priority, Mealy and combinational, highest first:
  1. mem_busy: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1; all flushes 0. br_taken and load_use are ignored, since EX is frozen and re-presents them after release.
  2. br_taken: if_id_flush=1, id_ex_flush=1, no stalls. This overrides load_use because the ID instruction is wrong-path.
  3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1. This gives exactly one bubble; the next cycle the load is in MEM and load_use deasserts.
  4. Otherwise all outputs are 0.
- Flush vs. stall on the same register: flush wins (never asserted together by the above rules).
- Transitions:
  - RUN→WAIT when mem_busy; wait_cnt←1.
  - WAIT→RUN when mem_ready; wait_cnt←0.
  - WAIT→WAIT when mem_busy & wait_cnt<MEM_TIMEOUT−1; wait_cnt+1.
  - WAIT→ABORT when mem_busy & wait_cnt==MEM_TIMEOUT−1. Registered mem_timeout=1 in ABORT; err_sticky←1.
  - WAIT→RUN when mem_req drops without mem_ready. This is a protocol violation; wait_cnt←0.
  - ABORT→RUN unconditionally. In ABORT, mem_busy is forced 0, so the pipeline advances one cycle and discards the access.
- A single-cycle access with mem_ready high in the request cycle causes no stall and no state change.
- wait_cnt saturates and never wraps.
- Reset mid-WAIT returns to RUN immediately; counters clear.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit output counters, cleared by reset and wrapping modulo 2^32:
  - perf_lu_stalls: cycles load_use was the winning cause.
  - perf_br_flushes: cycles br_taken was the winning cause.
  - perf_mem_stalls: cycles mem_busy was high.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - state enum (RUN, WAIT, ABORT), REG_ZERO=5'd0, NOP encoding used by the flush path.
- Sub-module hazard_detect: purely combinational load_use comparator, reusable by the forwarding unit.
- The FSM, wait counter and priority mux stay in hazard_ctrl.

Test Plan:
- Load-use: ex_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle. Also ex_rd=0 with the same inputs → no stall.
- Branch over load-use: br_taken=1 in the same cycle as the load-use above → if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high → all four stalls high 3 cycles. State sequence RUN→WAIT×3→RUN, no flushes, counter back to 0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → stalls high 4 cycles, then mem_timeout pulses 1 cycle with stalls low. err_sticky=1 until reset.
- Memory wait masks branch: br_taken=1 during WAIT → no flush until mem_ready; flush appears in the release cycle only if br_taken is still asserted.
- Reset mid-WAIT: assert reset in cycle 2 of a wait → next cycle all outputs 0, state RUN, err_sticky 0. With HAZARD_PERF_CNT_EN defined, all perf counters read 0.
